// File: rtl/al_bky_seq_pkg.sv
// Shared constants and state encoding for the Buckeye shift-chain load sequencer.
package al_bky_seq_pkg;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;
  localparam int unsigned TW = 24;

  localparam logic [TW-1:0] TMO_CYCLES_DEF = 24'd4000000;
  localparam logic [AW-1:0] NW_MAX_DEF     = 9'd511;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WAIT  = 3'd4,
    ST_FIN   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/al_bky_seq_rdpipe.sv
// Two-stage alignment: RD_EN plus the 1-cycle source latency become a registered
// CAPTURE strobe with AL_WORD, which holds its last value between strobes.
module al_bky_seq_rdpipe
  import al_bky_seq_pkg::*;
(
  input  logic          CLK40,
  input  logic          RST,
  input  logic          rd_en,
  input  logic [DW-1:0] rd_data,
  output logic          capture,
  output logic [DW-1:0] al_word
);

  logic rd_vld;

  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      rd_vld  <= 1'b0;
      capture <= 1'b0;
      al_word <= '0;
    end else begin
      rd_vld  <= rd_en;
      capture <= rd_vld;
      if (rd_vld) begin
        al_word <= rd_data;
      end
    end
  end

endmodule

// File: rtl/al_bky_load_seq.sv
// Buckeye shift-chain load sequencer: clears AL_DONE, streams NWORDS words to the loader
// FIFO, then waits for AL_DONE. Define AL_SEQ_TMO_EN to enable the TMO_CYCLES timeout.
module al_bky_load_seq
  import al_bky_seq_pkg::*;
#(
  parameter logic [TW-1:0] TMO_CYCLES = TMO_CYCLES_DEF,
  parameter logic [AW-1:0] NW_MAX     = NW_MAX_DEF
) (
  input  logic          CLK40,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] NWORDS,
  output logic          RD_EN,
  output logic [AW-1:0] RD_ADDR,
  input  logic [DW-1:0] RD_DATA,
  output logic          CAPTURE,
  output logic [DW-1:0] AL_WORD,
  output logic          CLR_AL_DONE,
  input  logic          AL_DONE,
  output logic          BUSY,
  output logic          LOAD_OK,
  output logic          TMO_ERR,
  output logic          SIZE_ERR
);

  seq_state_t    state;
  logic [AW-1:0] n_words;
  logic          drain_cnt;
  logic          size_bad_c;

  assign size_bad_c = (NWORDS == '0) || (NWORDS > NW_MAX);

  if (TMO_CYCLES == '0) begin : g_tmo_chk
    $error("al_bky_load_seq: TMO_CYCLES must be nonzero");
  end

`ifdef AL_SEQ_TMO_EN
  logic [TW-1:0] wait_cnt;
  logic [TW-1:0] wait_cnt_inc_c;
  logic          tmo_err_q;

  // Saturating increment; the counter value after this WAIT cycle.
  assign wait_cnt_inc_c = (wait_cnt == '1) ? wait_cnt : wait_cnt + TW'(1);
  assign TMO_ERR        = tmo_err_q;
`else
  assign TMO_ERR = 1'b0;
`endif

  always_ff @(posedge CLK40 or posedge RST) begin
    if (RST) begin
      state       <= ST_IDLE;
      n_words     <= '0;
      drain_cnt   <= 1'b0;
      RD_EN       <= 1'b0;
      RD_ADDR     <= '0;
      CLR_AL_DONE <= 1'b0;
      BUSY        <= 1'b0;
      LOAD_OK     <= 1'b0;
      SIZE_ERR    <= 1'b0;
`ifdef AL_SEQ_TMO_EN
      wait_cnt    <= '0;
      tmo_err_q   <= 1'b0;
`endif
    end else begin
      CLR_AL_DONE <= 1'b0;
      LOAD_OK     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            SIZE_ERR <= size_bad_c;
            n_words  <= NWORDS;
`ifdef AL_SEQ_TMO_EN
            tmo_err_q <= 1'b0;
`endif
            if (!size_bad_c) begin
              state       <= ST_CLR;
              CLR_AL_DONE <= 1'b1;
              BUSY        <= 1'b1;
            end
          end
        end
        ST_CLR: begin
          state   <= ST_FETCH;
          RD_EN   <= 1'b1;
          RD_ADDR <= '0;
        end
        ST_FETCH: begin
          if (RD_ADDR == n_words - AW'(1)) begin
            RD_EN     <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            RD_ADDR <= RD_ADDR + AW'(1);
          end
        end
        // Two cycles let the last word leave the read pipeline before WAIT.
        ST_DRAIN: begin
          if (drain_cnt) begin
            state <= ST_WAIT;
`ifdef AL_SEQ_TMO_EN
            wait_cnt <= '0;
`endif
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (AL_DONE) begin
            state   <= ST_FIN;
            LOAD_OK <= 1'b1;
            BUSY    <= 1'b0;
          end
`ifdef AL_SEQ_TMO_EN
          else if (wait_cnt_inc_c == TMO_CYCLES) begin
            state     <= ST_IDLE;
            tmo_err_q <= 1'b1;
            BUSY      <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt_inc_c;
          end
`endif
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  al_bky_seq_rdpipe u_rdpipe (
    .CLK40   (CLK40),
    .RST     (RST),
    .rd_en   (RD_EN),
    .rd_data (RD_DATA),
    .capture (CAPTURE),
    .al_word (AL_WORD)
  );

endmodule

// File: tb/tb_al_bky_load_seq.sv
// Scoreboard bench for al_bky_load_seq: the driver queues expected reads, captures,
// clears and completions per load; a negedge monitor pops and compares them.
module tb_al_bky_load_seq;

  localparam logic [23:0] TMO   = 24'd100;
  localparam logic [8:0]  NWMAX = 9'h1FE;
`ifdef AL_SEQ_TMO_EN
  localparam int LONG_DLY = 40;
`else
  localparam int LONG_DLY = 299;
`endif

  logic        CLK40 = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [8:0]  NWORDS = '0;
  logic        RD_EN;
  logic [8:0]  RD_ADDR;
  logic [15:0] RD_DATA = '0;
  logic        CAPTURE;
  logic [15:0] AL_WORD;
  logic        CLR_AL_DONE;
  logic        AL_DONE = 1'b0;
  logic        BUSY;
  logic        LOAD_OK;
  logic        TMO_ERR;
  logic        SIZE_ERR;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t        cap_q[$];
  exp_t        rd_q[$];
  exp_t        clr_q[$];
  exp_t        ok_q[$];
  logic [15:0] mem [512];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  al_bky_load_seq #(.TMO_CYCLES(TMO), .NW_MAX(NWMAX)) dut (
    .CLK40       (CLK40),
    .RST         (RST),
    .START       (START),
    .NWORDS      (NWORDS),
    .RD_EN       (RD_EN),
    .RD_ADDR     (RD_ADDR),
    .RD_DATA     (RD_DATA),
    .CAPTURE     (CAPTURE),
    .AL_WORD     (AL_WORD),
    .CLR_AL_DONE (CLR_AL_DONE),
    .AL_DONE     (AL_DONE),
    .BUSY        (BUSY),
    .LOAD_OK     (LOAD_OK),
    .TMO_ERR     (TMO_ERR),
    .SIZE_ERR    (SIZE_ERR)
  );

  always #5 CLK40 = ~CLK40;
  always @(posedge CLK40) cyc <= cyc + 1;

  // Word source with one cycle of read latency.
  always @(posedge CLK40) if (RD_EN) RD_DATA <= mem[RD_ADDR];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic tick();
    @(negedge CLK40);
  endtask

  // Monitor: every strobe the DUT presents must match the head of its queue.
  always @(negedge CLK40) begin : mon
    exp_t        e;
    logic [15:0] last_word;
    if (RST) begin
      last_word = '0;
    end else begin
      if (CAPTURE) begin
        if (cap_q.size() == 0) chk("cap_unexpected", int'(CAPTURE), 0);
        else begin
          e = cap_q.pop_front();
          chk("cap_cycle", cyc, e.cyc);
          chk("cap_word", int'(AL_WORD), e.val);
        end
        last_word = AL_WORD;
      end else begin
        chk("al_word_hold", int'(AL_WORD), int'(last_word));
      end
      if (RD_EN) begin
        if (rd_q.size() == 0) chk("rd_unexpected", int'(RD_EN), 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", int'(RD_ADDR), e.val);
        end
      end
      if (CLR_AL_DONE) begin
        if (clr_q.size() == 0) chk("clr_unexpected", int'(CLR_AL_DONE), 0);
        else begin
          e = clr_q.pop_front();
          chk("clr_cycle", cyc, e.cyc);
        end
      end
      if (LOAD_OK) begin
        if (ok_q.size() == 0) chk("ok_unexpected", int'(LOAD_OK), 0);
        else begin
          e = ok_q.pop_front();
          chk("ok_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Queue what an accepted START at cycle t must produce for n words.
  task automatic push_load(input int t, input int n);
    clr_q.push_back('{t + 1, 0});
    for (int k = 0; k < n; k++) begin
      rd_q.push_back('{t + 2 + k, k});
      cap_q.push_back('{t + 4 + k, int'(mem[k])});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_capture"}, int'(CAPTURE), 0);
    chk({tag, "_al_word"}, int'(AL_WORD), 0);
    chk({tag, "_rd_en"}, int'(RD_EN), 0);
    chk({tag, "_rd_addr"}, int'(RD_ADDR), 0);
    chk({tag, "_clr"}, int'(CLR_AL_DONE), 0);
    chk({tag, "_load_ok"}, int'(LOAD_OK), 0);
    chk({tag, "_tmo_err"}, int'(TMO_ERR), 0);
    chk({tag, "_size_err"}, int'(SIZE_ERR), 0);
  endtask

  // Full load: START at the current cycle t, AL_DONE rises done_dly cycles into WAIT.
  task automatic run_load(input int n, input int done_dly, input bit noise,
                          input bit stale, input int xstart);
    int t, w, d;
    t = cyc;
    START  = 1'b1;
    NWORDS = 9'(n);
    push_load(t, n);
    tick();
    START = 1'b0;
    chk("busy_t1", int'(BUSY), 1);
    chk("size_err_cleared", int'(SIZE_ERR), 0);
    chk("tmo_err_cleared", int'(TMO_ERR), 0);
    w = t + n + 4;
    while (cyc < w) begin
      AL_DONE = (stale && cyc < t + 4) ? 1'b1 : (noise ? 1'($urandom_range(1, 0)) : 1'b0);
      START   = (xstart > 0 && cyc == t + xstart) || (noise && $urandom_range(3, 0) == 0);
      NWORDS  = 9'($urandom_range(20, 1));
      tick();
    end
    START   = 1'b0;
    AL_DONE = 1'b0;
    repeat (done_dly) tick();
    d = cyc;
    chk("busy_last_wait", int'(BUSY), 1);
    AL_DONE = 1'b1;
    ok_q.push_back('{d + 1, 0});
    tick();
    chk("busy_fin", int'(BUSY), 0);
    chk("tmo_err_fin", int'(TMO_ERR), 0);
    AL_DONE = 1'b0;
    tick();
    chk("load_ok_one_cycle", int'(LOAD_OK), 0);
    chk("busy_idle", int'(BUSY), 0);
  endtask

  task automatic size_err_case(input int n);
    START  = 1'b1;
    NWORDS = 9'(n);
    tick();
    START = 1'b0;
    chk("size_err_set", int'(SIZE_ERR), 1);
    chk("size_busy", int'(BUSY), 0);
    chk("size_clr", int'(CLR_AL_DONE), 0);
    repeat (6) tick();
    chk("size_err_sticky", int'(SIZE_ERR), 1);
    chk("size_busy_later", int'(BUSY), 0);
    chk("size_rd_en", int'(RD_EN), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : drive
    int t;
    for (int i = 0; i < 512; i++) mem[i] = 16'hA000 + 16'(i);

    repeat (3) tick();
    chk_all_zero("reset");
    RST = 1'b0;
    repeat (2) tick();

    // 18-word load, AL_DONE well after the last capture.
    run_load(18, LONG_DLY, 1'b0, 1'b0, -1);

    // Size errors: zero words and one past NW_MAX.
    size_err_case(0);
    size_err_case(9'h1FF);

    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);

    // Second START during FETCH must be ignored.
    run_load(5, 10, 1'b0, 1'b0, 3);

    // Stale AL_DONE from before START.
    AL_DONE = 1'b1;
    repeat (3) tick();
    run_load(6, 20, 1'b0, 1'b1, -1);

    // Reset at the 3rd capture of a 10-word load.
    t = cyc;
    START  = 1'b1;
    NWORDS = 9'd10;
    push_load(t, 10);
    tick();
    START = 1'b0;
    while (cyc < t + 6) tick();
    #2 RST = 1'b1;
    #1 chk_all_zero("mid_rst");
    chk("rst_caps_before", cap_q.size(), 7);
    cap_q.delete();
    rd_q.delete();
    clr_q.delete();
    ok_q.delete();
    repeat (2) tick();
    RST = 1'b0;
    repeat (5) tick();
    run_load(10, 3, 1'b0, 1'b0, -1);

    // Boundaries: one word with AL_DONE on the first WAIT cycle; NW_MAX words.
    run_load(1, 0, 1'b0, 1'b0, -1);
    run_load(int'(NWMAX), 5, 1'b0, 1'b0, -1);

    // Randomized loads with START/AL_DONE noise outside WAIT.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      run_load(int'($urandom_range(40, 1)), int'($urandom_range(60, 0)), 1'b1, 1'b0, -1);
    end

`ifdef AL_SEQ_TMO_EN
    // Timeout with AL_DONE held low, then recovery and the priority boundary.
    t = cyc;
    START  = 1'b1;
    NWORDS = 9'd3;
    push_load(t, 3);
    tick();
    START = 1'b0;
    while (cyc < t + 7 + 99) tick();
    chk("tmo_not_yet", int'(TMO_ERR), 0);
    chk("tmo_busy_last_wait", int'(BUSY), 1);
    tick();
    chk("tmo_err_set", int'(TMO_ERR), 1);
    chk("tmo_busy_drop", int'(BUSY), 0);
    chk("tmo_no_load_ok", int'(LOAD_OK), 0);
    repeat (3) tick();
    chk("tmo_err_sticky", int'(TMO_ERR), 1);
    run_load(4, 10, 1'b0, 1'b0, -1);
    run_load(3, int'(TMO) - 1, 1'b0, 1'b0, -1);
`endif

    repeat (5) tick();
    chk("cap_q_empty", cap_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("clr_q_empty", clr_q.size(), 0);
    chk("ok_q_empty", ok_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
